// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the scanning decoder: mode encodings and FSM states.
package decoder_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  // Width of a down/up counter able to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2**N one-hot decoder with enable; all-zero when disabled.
module dec_onehot #(
  parameter int N = 4
) (
  input  logic [N-1:0]      sel,
  input  logic              en,
  output logic [2**N-1:0]   y
);

  // One comparator per output bit keeps the decode obviously one-hot.
  generate
    for (genvar gi = 0; gi < 2**N; gi++) begin : g_bit
      assign y[gi] = en && (sel == N'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_scan.sv
// Decoder with three behaviours: level decode, timed single pulse and a
// free-running scan across all outputs. All outputs come straight from flops.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N        = 4,
  parameter int PW       = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      addr,
  input  logic              req,
  input  logic [PW-1:0]     pulse_len,
  output logic [2**N-1:0]   d,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              done
);

  localparam int               W        = 2**N;
  localparam int               DW       = cnt_width(SCAN_DIV);
  localparam logic [N-1:0]     IDX_LAST = {N{1'b1}};
  localparam logic [DW-1:0]    DIV_LAST = DW'(SCAN_DIV - 1);

  state_t          state_reg, state_next;
  logic [N-1:0]    idx_reg, idx_next;
  logic [PW-1:0]   pcnt_reg, pcnt_next;   // pulse cycles remaining after the current one
  logic [DW-1:0]   dcnt_reg, dcnt_next;   // cycles already spent on the current scan index
  logic            drive_next;            // next cycle shows a decoded bit
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic [W-1:0]    d_reg;
  logic [W-1:0]    dec_y;

  // The single decoder looks at the index chosen for the next cycle so that
  // d can be captured directly into a register.
  dec_onehot #(.N(N)) u_dec (
    .sel (idx_next),
    .en  (drive_next),
    .y   (dec_y)
  );

  // Next-state selection; aborts drop straight back to IDLE with no done.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    pcnt_next  = pcnt_reg;
    dcnt_next  = dcnt_reg;
    drive_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        idx_next  = '0;
        pcnt_next = '0;
        dcnt_next = '0;
        if (en) begin
          case (mode)
            MODE_LEVEL: begin
              idx_next   = addr;
              drive_next = 1'b1;
            end
            MODE_PULSE: begin
              if (req) begin
                state_next = ST_PULSE;
                idx_next   = addr;
                // A zero length is treated as a single-cycle pulse.
                pcnt_next  = (pulse_len == '0) ? '0 : pulse_len - PW'(1);
                drive_next = 1'b1;
              end
            end
            MODE_SCAN: begin
              state_next = ST_SCAN;
              drive_next = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_PULSE: begin
        if (!en || mode != MODE_PULSE || pcnt_reg == '0) begin
          state_next = ST_IDLE;
          idx_next   = '0;
          pcnt_next  = '0;
        end else begin
          pcnt_next  = pcnt_reg - PW'(1);
          drive_next = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!en || mode != MODE_SCAN) begin
          state_next = ST_IDLE;
          idx_next   = '0;
          dcnt_next  = '0;
        end else begin
          drive_next = 1'b1;
          if (dcnt_reg == DIV_LAST) begin
            dcnt_next = '0;
            idx_next  = idx_reg + N'(1);   // natural wrap from the last index to 0
          end else begin
            dcnt_next = dcnt_reg + DW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
        pcnt_next  = '0;
        dcnt_next  = '0;
      end
    endcase
  end

  // Status flags for the cycle about to be presented.
  always_comb begin
    busy_next = (state_next != ST_IDLE);
    done_next = ((state_next == ST_PULSE) && (pcnt_next == '0)) ||
                ((state_next == ST_SCAN) && (idx_next == IDX_LAST) && (dcnt_next == DIV_LAST));
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      pcnt_reg  <= '0;
      dcnt_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      d_reg     <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      pcnt_reg  <= pcnt_next;
      dcnt_reg  <= dcnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      d_reg     <= dec_y;
    end
  end

  assign d    = d_reg;
  assign idx  = idx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_decoder_scan.sv
// Randomised and directed bench for decoder_scan; two instances (N=4/DIV=4 and
// N=3/DIV=1) share stimulus and are checked against a time-based model.
module tb_decoder_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  addr4 = '0;
  logic [2:0]  addr3 = '0;
  logic        req = 1'b0;
  logic [7:0]  pulse_len = '0;

  logic [15:0] d4;
  logic [3:0]  idx4;
  logic        busy4, done4;
  logic [7:0]  d3;
  logic [2:0]  idx3;
  logic        busy3, done3;

  always #5 clk = ~clk;

  decoder_scan #(.N(4), .PW(8), .SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr4), .req(req),
    .pulse_len(pulse_len), .d(d4), .idx(idx4), .busy(busy4), .done(done4)
  );

  decoder_scan #(.N(3), .PW(8), .SCAN_DIV(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .addr(addr3), .req(req),
    .pulse_len(pulse_len), .d(d3), .idx(idx3), .busy(busy3), .done(done3)
  );

  // Model: st 0 idle, 1 pulse, 2 scan. Pulse tracks cycles left; scan tracks
  // elapsed cycles t, from which index and done follow arithmetically.
  typedef struct {
    int          st;
    int          left;
    int          paddr;
    int          t;
    logic [63:0] d;
    int          idx;
    bit          busy;
    bit          done;
  } mdl_t;

  typedef struct {
    int          cyc;
    logic [63:0] d;
    int          idx;
    bit          busy;
    bit          done;
  } exp_t;

  mdl_t m4, m3;
  exp_t q4[$];
  exp_t q3[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t mstep(mdl_t m, bit r, bit e, logic [1:0] md, int a,
                                 bit rq, int pl, int n, int div);
    int prev;
    int period;
    int k;
    prev   = m.st;
    period = div * (1 << n);
    if (r) begin
      m.st = 0;
    end else begin
      case (m.st)
        0: begin
          if (e && md == 2'b01 && rq) begin
            m.st = 1; m.paddr = a; m.left = (pl == 0) ? 1 : pl;
          end else if (e && md == 2'b10) begin
            m.st = 2; m.t = 0;
          end
        end
        1: if (!e || md != 2'b01 || m.left == 1) m.st = 0; else m.left = m.left - 1;
        2: if (!e || md != 2'b10) m.st = 0; else m.t = m.t + 1;
        default: m.st = 0;
      endcase
    end
    m.d = 64'd0; m.idx = 0; m.busy = 0; m.done = 0;
    if (!r) begin
      if (prev == 0 && m.st == 0 && e && md == 2'b00) begin
        m.d = 64'd1 << a; m.idx = a;
      end else if (m.st == 1) begin
        m.d = 64'd1 << m.paddr; m.idx = m.paddr; m.busy = 1; m.done = (m.left == 1);
      end else if (m.st == 2) begin
        k = (m.t / div) % (1 << n);
        m.d = 64'd1 << k; m.idx = k; m.busy = 1;
        m.done = ((m.t % period) == period - 1);
      end
    end
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of stimulus and queue what both instances must show next.
  task automatic step(input bit r, input bit e, input logic [1:0] md, input int a,
                      input bit rq, input int pl);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; mode = md; addr4 = a[3:0]; addr3 = a[2:0]; req = rq; pulse_len = pl[7:0];
    m4 = mstep(m4, r, e, md, a & 15, rq, pl & 255, 4, 4);
    m3 = mstep(m3, r, e, md, a & 7,  rq, pl & 255, 3, 1);
    x.cyc = cyc + 1;
    x.d = m4.d; x.idx = m4.idx; x.busy = m4.busy; x.done = m4.done;
    q4.push_back(x);
    x.d = m3.d; x.idx = m3.idx; x.busy = m3.busy; x.done = m3.done;
    q3.push_back(x);
  endtask

  // Monitor: compare whatever each DUT presents against the queued expectation.
  always @(negedge clk) begin
    exp_t x;
    while (q4.size() > 0 && q4[0].cyc == cyc) begin
      x = q4.pop_front();
      checks++;
      if ({48'd0, d4} !== x.d || 32'(idx4) !== x.idx || busy4 !== x.busy || done4 !== x.done) begin
        errors++;
        $display("FAIL n4_out cyc=%0d got d=%h idx=%0d busy=%b done=%b exp d=%h idx=%0d busy=%b done=%b",
                 cyc, d4, idx4, busy4, done4, x.d[15:0], x.idx, x.busy, x.done);
      end
      checks++;
      if (!$onehot0(d4)) begin
        errors++;
        $display("FAIL n4_onehot cyc=%0d got d=%h exp at most one bit set", cyc, d4);
      end
    end
    while (q3.size() > 0 && q3[0].cyc == cyc) begin
      x = q3.pop_front();
      checks++;
      if ({56'd0, d3} !== x.d || 32'(idx3) !== x.idx || busy3 !== x.busy || done3 !== x.done) begin
        errors++;
        $display("FAIL n3_out cyc=%0d got d=%h idx=%0d busy=%b done=%b exp d=%h idx=%0d busy=%b done=%b",
                 cyc, d3, idx3, busy3, done3, x.d[7:0], x.idx, x.busy, x.done);
      end
      checks++;
      if (!$onehot0(d3)) begin
        errors++;
        $display("FAIL n3_onehot cyc=%0d got d=%h exp at most one bit set", cyc, d3);
      end
    end
  end

  initial begin
    logic [1:0] rmode;
    m4 = '{default: 0};
    m3 = '{default: 0};

    // Reset state.
    step(1, 0, 2'b00, 0, 0, 0);
    step(1, 1, 2'b10, 5, 1, 3);
    step(0, 0, 2'b00, 0, 0, 0);

    // LEVEL decode then disable.
    step(0, 1, 2'b00, 9, 0, 0);
    step(0, 1, 2'b00, 5, 0, 0);
    step(0, 0, 2'b00, 5, 0, 0);

    // PULSE of 5 with a stray req and addr changes mid-pulse.
    step(0, 1, 2'b01, 3, 1, 5);
    for (int i = 0; i < 7; i++) step(0, 1, 2'b01, (i == 1) ? 7 : 3, (i == 2), 2);

    // pulse_len = 0 behaves as one cycle.
    step(0, 1, 2'b01, 6, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 6, 0, 0);

    // Full SCAN through the wrap, then mode change and reserved mode.
    for (int i = 0; i < 70; i++) step(0, 1, 2'b10, 0, 0, 0);
    step(0, 1, 2'b11, 2, 1, 4);
    step(0, 1, 2'b11, 2, 1, 4);

    // Abort scan by dropping en at cycle 10.
    for (int i = 0; i < 10; i++) step(0, 1, 2'b10, 0, 0, 0);
    step(0, 0, 2'b10, 0, 0, 0);
    step(0, 0, 2'b10, 0, 0, 0);

    // Mode 01 -> 10 mid-pulse aborts.
    step(0, 1, 2'b01, 2, 1, 6);
    step(0, 1, 2'b01, 2, 0, 6);
    step(0, 1, 2'b10, 2, 0, 6);
    step(0, 0, 2'b00, 0, 0, 0);

    // Reset mid-pulse with en and req high.
    step(0, 1, 2'b01, 4, 1, 9);
    step(0, 1, 2'b01, 4, 0, 9);
    step(1, 1, 2'b01, 4, 1, 9);
    step(0, 0, 2'b00, 0, 0, 0);

    // Reserved mode stays idle.
    for (int i = 0; i < 3; i++) step(0, 1, 2'b11, 5, 1, 3);

    // Random traffic with sticky mode.
    rmode = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rmode = 2'($urandom_range(0, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 31) != 0, rmode,
           int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)));
    end
    step(0, 0, 2'b00, 0, 0, 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && (q4.size() > 0 || q3.size() > 0); i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (q4.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", q4.size(), q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
